// File: rtl/proc_pkg.sv
// Shared event codes, record layout and pending-slot type
// for the event serializer slice.
package proc_pkg;

  localparam logic [1:0] EV_NONE    = 2'b00;
  localparam logic [1:0] EV_CLASS_A = 2'b01;
  localparam logic [1:0] EV_CLASS_B = 2'b10;
  localparam logic [1:0] EV_BOTH    = 2'b11;

  localparam int CLASS_W = 2;
  localparam int UNIT_W  = 2;
  localparam int TS_W    = 4;
  localparam int REC_W   = CLASS_W + UNIT_W + TS_W;

  localparam int TS_LSB    = 0;
  localparam int UNIT_LSB  = TS_LSB + TS_W;
  localparam int CLASS_LSB = UNIT_LSB + UNIT_W;

  typedef struct packed {
    logic              v;
    logic [CLASS_W-1:0] cls;
    logic [TS_W-1:0]   ts;
  } slot_t;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [CLASS_W-1:0] cls,
    input logic [UNIT_W-1:0]  unit,
    input logic [TS_W-1:0]    ts
  );
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[CLASS_LSB +: CLASS_W] = cls;
    rec[UNIT_LSB +: UNIT_W]   = unit;
    rec[TS_LSB +: TS_W]       = ts;
    return rec;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead record FIFO; rdata reads as zero while empty.
// Push on a full FIFO is ignored, so a simultaneous pop wins.
module event_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [4:0]       lvl;
  logic             do_push;
  logic             do_pop;

  assign full    = (lvl == 5'(DEPTH));
  assign empty   = (lvl == 5'd0);
  assign level   = lvl;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   lvl <= lvl + 5'd1;
        2'b01:   lvl <= lvl - 5'd1;
        default: lvl <= lvl;
      endcase
    end
  end

endmodule

// File: rtl/event_serializer.sv
// Per-unit pending slots, round-robin arbiter and drop counter
// feeding event_fifo. Timestamps: EVENT_SERIALIZER_TIMESTAMP_EN.
module event_serializer
  import proc_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_UNITS-1:0] event_in_array,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             fifo_level,
  output logic [7:0]             drop_count
);

  slot_t       slots   [NUM_UNITS];
  slot_t       slots_d [NUM_UNITS];
  logic [1:0]  rr_ptr;
  logic [3:0]  ts_now;
  logic        fifo_full;
  logic        fifo_empty;
  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [2:0]  n_drop;
  logic [7:0]  push_rec;
  logic [8:0]  drop_sum;

`ifdef EVENT_SERIALIZER_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst) ts_cnt <= '0;
    else      ts_cnt <= ts_cnt + 16'd1;
  end

  assign ts_now = ts_cnt[3:0];
`else
  assign ts_now = 4'h0;
`endif

  // First valid slot at or after rr_ptr, only when the FIFO has room.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!fifo_full && !gnt_found &&
          slots[(int'(rr_ptr) + k) % NUM_UNITS].v) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'((int'(rr_ptr) + k) % NUM_UNITS);
      end
    end
  end

  // A granted slot frees up in the same cycle, so a new event refills it.
  always_comb begin
    n_drop = '0;
    for (int j = 0; j < NUM_UNITS; j++) begin
      slots_d[j] = slots[j];
      if (gnt_found && gnt_idx == 2'(j)) slots_d[j].v = 1'b0;
      if (event_in_array[2*j +: 2] != EV_NONE) begin
        if (slots_d[j].v) begin
          n_drop = n_drop + 3'd1;
        end else begin
          slots_d[j].v   = 1'b1;
          slots_d[j].cls = event_in_array[2*j +: 2];
          slots_d[j].ts  = ts_now;
        end
      end
    end
  end

  assign push_rec = pack_rec(slots[gnt_idx].cls, gnt_idx,
                             slots[gnt_idx].ts);
  assign drop_sum = {1'b0, drop_count} + 9'(n_drop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUM_UNITS; j++) slots[j] <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      for (int j = 0; j < NUM_UNITS; j++) slots[j] <= slots_d[j];
      if (gnt_found) begin
        rr_ptr <= (gnt_idx == 2'(NUM_UNITS - 1)) ? 2'd0
                                                : gnt_idx + 2'd1;
      end
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_found),
    .wdata (push_rec),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;

endmodule
